// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM behind the processor data port,
// with programmable stall latency and sticky protocol/range error flags.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    output logic                 ProtoErr,
    output logic                 RangeErr
);

    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] WR_LAT = CNT_W'(WRITE_LATENCY);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic                   wr_q, wr_d;
    logic                   proto_q, range_q;

    logic [WORD_SIZE-1:0]   mem [DEPTH];

    logic                   req;
    logic [CNT_W-1:0]       lat;
    logic                   in_range;
    logic [ADDR_BITS-1:0]   idx;
    logic                   mismatch;
    logic                   waitreq_c;
    logic                   ack_c;
    logic                   proto_set;
    logic                   range_set;

    // Request decode; a simultaneous read+write is handled as a write
    assign req      = ReadData | WriteData;
    assign lat      = WriteData ? WR_LAT : RD_LAT;
    assign in_range = ((DataAddr >> ADDR_BITS) == '0);
    assign idx      = DataAddr[ADDR_BITS-1:0];
    assign mismatch = (DataAddr != addr_q) || (WriteData != wr_q);

    // Next-state and stall generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        waitreq_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && (lat != '0)) begin
                    waitreq_c = 1'b1;
                    addr_d    = DataAddr;
                    wr_d      = WriteData;
                    cnt_d     = CNT_W'(1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (mismatch) begin
                    waitreq_c = 1'b1;
                    addr_d    = DataAddr;
                    wr_d      = WriteData;
                    cnt_d     = CNT_W'(1);
                end else if (cnt_q >= lat) begin
                    // >= so a relatched zero-latency request still completes
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    waitreq_c = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset forces the port quiet immediately, so no ack and no stall
    assign DataWaitreq = Resetn & waitreq_c;
    assign ack_c       = Resetn & req & ~waitreq_c;
    assign proto_set   = (req & ReadData & WriteData)
                       | ((state_q == WAIT) & req & mismatch);
    assign range_set   = ack_c & ~in_range;

    // Combinational read data, only driven in a read ack cycle
    assign DataIn = (ack_c && !WriteData && in_range) ? mem[idx] : '0;

    assign ProtoErr = proto_q;
    assign RangeErr = range_q;

    // State register, latched request fields and sticky error flags
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            proto_q <= 1'b0;
            range_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            proto_q <= proto_q | proto_set;
            range_q <= range_q | range_set;
        end
    end

    // RAM write at the end of an in-range write ack cycle
    always_ff @(posedge Clock) begin
        if (ack_c && WriteData && in_range) begin
            mem[idx] <= DataOut;
        end
    end

endmodule
